// File: rtl/writeback_arbiter.sv
// Shares one register-file write port between an ALU result and a 2-entry load FIFO,
// with round-robin arbitration, a WAW guard on the ALU, and a pending-write scoreboard.
module writeback_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [5:0]  lsu_opcode,
  input  logic [63:0] lsu_data,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  input  logic [4:0]  chk_rs,
  input  logic [4:0]  chk_rt,
  output logic [31:0] pending,
  output logic        hazard
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  wb_entry_t        fifo_q [DEPTH];
  wb_entry_t        fifo_d [DEPTH];
  logic             head_q, head_d;
  logic [CNT_W-1:0] count_q, count_d;
  src_e             last_q, last_d;
  logic             wb_en_d;
  logic [REG_W-1:0] wb_rd_d;
  logic [XLEN-1:0]  wb_data_d;

  logic [DEPTH-1:0] slot_vld;
  logic             waw;
  logic             alu_go;
  logic             lsu_go;
  logic             enq;
  logic             tail;

  // Width/sign selection for load data, applied as the entry is enqueued.
  function automatic logic [XLEN-1:0] extend(input logic [OP_W-1:0] op,
                                             input logic [XLEN-1:0] d);
    case (op)
      6'd34:   return XLEN'(d[7:0]);
      6'd40:   return XLEN'(d[15:0]);
      6'd42:   return {{(XLEN-16){d[15]}}, d[15:0]};
      6'd32:   return XLEN'(d[31:0]);
      default: return d;
    endcase
  endfunction

  // Slot occupancy and WAW match against every queued load.
  always_comb begin
    slot_vld = '0;
    waw      = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_vld[i] = (1'(i) == head_q) ? (count_q != '0) : (count_q == CNT_W'(DEPTH));
      if (slot_vld[i] && (fifo_q[i].rd == alu_rd)) waw = 1'b1;
    end
  end

  // alu_ready depends on state and alu_rd only, so alu_valid never feeds back into it.
  assign alu_ready = !rst && !waw && ((count_q == '0) || (last_q == SRC_LSU));
  assign lsu_ready = !rst && (count_q < CNT_W'(DEPTH));
  assign alu_go    = alu_valid && alu_ready;
  assign lsu_go    = !rst && (count_q != '0) && !alu_go;
  assign enq       = lsu_valid && lsu_ready;
  assign tail      = head_q ^ count_q[0];

  // Next-state: enqueue, grant, and writeback register update.
  always_comb begin
    fifo_d    = fifo_q;
    head_d    = head_q;
    count_d   = count_q;
    last_d    = last_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd;
    wb_data_d = wb_data;

    if (enq) begin
      fifo_d[tail].rd   = lsu_rd;
      fifo_d[tail].data = extend(lsu_opcode, lsu_data);
    end

    if (alu_go) begin
      wb_en_d   = 1'b1;
      wb_rd_d   = alu_rd;
      wb_data_d = alu_data;
      last_d    = SRC_ALU;
    end else if (lsu_go) begin
      wb_en_d   = 1'b1;
      wb_rd_d   = fifo_q[head_q].rd;
      wb_data_d = fifo_q[head_q].data;
      head_d    = ~head_q;
      last_d    = SRC_LSU;
    end

    count_d = count_q + CNT_W'(enq) - CNT_W'(lsu_go);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= 1'b0;
      count_q <= '0;
      last_q  <= SRC_LSU;
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      fifo_q  <= fifo_d;
      head_q  <= head_d;
      count_q <= count_d;
      last_q  <= last_d;
      wb_en   <= wb_en_d;
      wb_rd   <= wb_rd_d;
      wb_data <= wb_data_d;
    end
  end

  // Registers with a write still queued or on the write port this cycle.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_vld[i]) pending[fifo_q[i].rd] = 1'b1;
    end
    if (wb_en) pending[wb_rd] = 1'b1;
  end

  assign hazard = pending[chk_rs] | pending[chk_rt];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, extension, round-robin, WAW, hazard, reset mid-flight.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [5:0]  lsu_opcode;
  logic [63:0] lsu_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [4:0]  chk_rs;
  logic [4:0]  chk_rt;
  logic [31:0] pending;
  logic        hazard;

  int checks = 0;
  int passed = 0;

  writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_opcode(lsu_opcode), .lsu_data(lsu_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .chk_rs(chk_rs), .chk_rt(chk_rt), .pending(pending), .hazard(hazard)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_wb(input string tag, input logic [4:0] rd, input logic [63:0] data);
    check({tag, "_en"}, 64'(wb_en), 64'd1);
    check({tag, "_rd"}, 64'(wb_rd), 64'(rd));
    check({tag, "_data"}, wb_data, data);
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_opcode = '0; lsu_data = '0;
    chk_rs = 5'd4; chk_rt = 5'd20;

    // Reset state
    tick(); tick();
    check("rst_alu_ready", 64'(alu_ready), 64'd0);
    check("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    check("rst_wb_en", 64'(wb_en), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    rst = 1'b0; #1;
    check("post_rst_alu_ready", 64'(alu_ready), 64'd1);
    check("post_rst_lsu_ready", 64'(lsu_ready), 64'd1);
    check("post_rst_hazard", 64'(hazard), 64'd0);

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    tick();
    alu_valid = 1'b0;
    check_wb("alu_only", 5'd5, 64'h1234);
    check("alu_only_pending", 64'(pending), 64'h20);
    tick();
    check("alu_idle_en", 64'(wb_en), 64'd0);
    check("alu_idle_rd_hold", 64'(wb_rd), 64'd5);
    check("alu_idle_pending", 64'(pending), 64'd0);

    // Load extension: two cycles from accept to write
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_opcode = 6'd42; lsu_data = 64'h1234_5678_9ABC_8001;
    tick();
    lsu_valid = 1'b0;
    check("ld42_queued_en", 64'(wb_en), 64'd0);
    check("ld42_pending", 64'(pending), 64'h400);
    tick();
    check_wb("ld42", 5'd10, 64'hFFFF_FFFF_FFFF_8001);
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_opcode = 6'd34; lsu_data = 64'hFFFF_FFFF_FFFF_FFAB;
    tick();
    lsu_valid = 1'b0;
    tick();
    check_wb("ld34", 5'd11, 64'hAB);

    // Back-to-back loads: simultaneous enqueue/dequeue keeps order
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_opcode = 6'd40; lsu_data = 64'hFFFF_FFFF_FFFF_8001;
    tick();
    lsu_rd = 5'd13; lsu_opcode = 6'd32; lsu_data = 64'hFFFF_FFFF_8765_4321;
    tick();
    check_wb("ld40", 5'd12, 64'h8001);
    check("ld40_pending", 64'(pending), 64'h3000);
    lsu_rd = 5'd14; lsu_opcode = 6'd7; lsu_data = 64'hDEAD_BEEF_0123_4567;
    tick();
    check_wb("ld32", 5'd13, 64'h8765_4321);
    lsu_valid = 1'b0;
    tick();
    check_wb("ld_pass", 5'd14, 64'hDEAD_BEEF_0123_4567);
    tick();
    check("ld_drain_en", 64'(wb_en), 64'd0);

    // Tie and round-robin: ALU rd=7 against loads to rd=3
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_opcode = 6'd0; lsu_data = 64'h30;
    #1 check("rr_c0_alu_ready", 64'(alu_ready), 64'd1);
    tick();
    check_wb("rr_g1_alu", 5'd7, 64'h77);
    lsu_data = 64'h31;
    #1 check("rr_c1_alu_ready", 64'(alu_ready), 64'd0);
    tick();
    check_wb("rr_g2_lsu", 5'd3, 64'h30);
    lsu_data = 64'h32;
    #1 check("rr_c2_alu_ready", 64'(alu_ready), 64'd1);
    tick();
    check_wb("rr_g3_alu", 5'd7, 64'h77);
    lsu_data = 64'h33;
    #1 check("rr_full_lsu_ready", 64'(lsu_ready), 64'd0);
    check("rr_full_alu_ready", 64'(alu_ready), 64'd0);
    tick();
    check_wb("rr_g4_lsu", 5'd3, 64'h31);
    lsu_valid = 1'b0;
    tick();
    check_wb("rr_g5_alu", 5'd7, 64'h77);
    tick();
    check_wb("rr_g6_lsu", 5'd3, 64'h32);
    alu_valid = 1'b0;
    tick();
    check("rr_no_extra_en", 64'(wb_en), 64'd0);

    // WAW guard: ALU rd=9 waits for the queued rd=9 load
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 64'h90;
    tick();
    lsu_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
    #1 check("waw_alu_ready", 64'(alu_ready), 64'd0);
    tick();
    check_wb("waw_lsu_first", 5'd9, 64'h90);
    check("waw_release_ready", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    check_wb("waw_alu_second", 5'd9, 64'h99);

    // Hazard on a queued load to rd=4, through its write cycle
    tick();
    check("hz_before", 64'(hazard), 64'd0);
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'h44;
    tick();
    lsu_valid = 1'b0;
    check("hz_queued", 64'(hazard), 64'd1);
    tick();
    chk_rs = 5'd1; chk_rt = 5'd4;
    #1 check("hz_wb_cycle_rt", 64'(hazard), 64'd1);
    check_wb("hz_wb", 5'd4, 64'h44);
    tick();
    check("hz_after", 64'(hazard), 64'd0);

    // Register 0 is ordinary
    chk_rs = 5'd0; chk_rt = 5'd31;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h5;
    tick();
    alu_valid = 1'b0;
    check_wb("r0_write", 5'd0, 64'h5);
    check("r0_pending", 64'(pending), 64'h1);
    check("r0_hazard", 64'(hazard), 64'd1);
    tick();

    // Reset mid-operation with a full FIFO and a write on the port
    chk_rs = 5'd17; chk_rt = 5'd18;
    alu_valid = 1'b1; alu_rd = 5'd15; alu_data = 64'hF0;
    lsu_valid = 1'b1; lsu_rd = 5'd16; lsu_data = 64'h160;
    tick();
    lsu_rd = 5'd17; lsu_data = 64'h170;
    tick();
    check_wb("mid_lsu16", 5'd16, 64'h160);
    lsu_rd = 5'd18; lsu_data = 64'h180;
    tick();
    check_wb("mid_alu15", 5'd15, 64'hF0);
    check("mid_full_ready", 64'(lsu_ready), 64'd0);
    check("mid_pending", 64'(pending), 64'h0006_8000);
    rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
    #1 check("mid_rst_alu_ready", 64'(alu_ready), 64'd0);
    check("mid_rst_lsu_ready", 64'(lsu_ready), 64'd0);
    tick();
    rst = 1'b0;
    check("mid_rst_wb_en", 64'(wb_en), 64'd0);
    check("mid_rst_wb_rd", 64'(wb_rd), 64'd0);
    check("mid_rst_pending", 64'(pending), 64'd0);
    check("mid_rst_hazard", 64'(hazard), 64'd0);
    #1 check("mid_post_lsu_ready", 64'(lsu_ready), 64'd1);
    check("mid_post_alu_ready", 64'(alu_ready), 64'd1);
    tick();
    check("mid_no_stale_1", 64'(wb_en), 64'd0);
    tick();
    check("mid_no_stale_2", 64'(wb_en), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
